// File: rtl/tiny45_alu_seq.sv
// Nibble-serial sequencer for the tiny45 datapath: latches a 32-bit ALU/shift op and
// feeds the 4-bit ALU/shifter LSB-first over 8 cycles, chaining carry and compare.
module tiny45_alu_seq (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [3:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic        ready,
    output logic        done,
    output logic [31:0] result,
    output logic        cmp,
    output logic [3:0]  alu_op,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic        alu_cy_in,
    output logic        alu_cmp_in,
    input  logic [3:0]  alu_d,
    input  logic        alu_cy_out,
    input  logic        alu_cmp_res,
    output logic [2:0]  shift_counter,
    output logic [31:0] shift_a,
    output logic [4:0]  shift_b,
    input  logic [3:0]  shift_d
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t      r_state;
    state_t      w_next;
    logic [2:0]  r_cnt;
    logic [3:0]  r_op;
    logic [31:0] r_a;
    logic [31:0] r_b;
    logic [31:0] r_sr;
    logic [31:0] r_result;
    logic        r_cmp;
    logic        r_cy;
    logic        r_cmpc;

    logic        w_accept;
    logic        w_first;
    logic        w_slt_op;
    logic [3:0]  w_nib;
    logic [4:0]  w_idx;

    assign ready    = (r_state != S_RUN);
    assign done     = (r_state == S_DONE);
    assign w_accept = start & ready;
    assign w_first  = (r_cnt == 3'd0);
    assign w_slt_op = (r_op[3:1] == 3'b001);
    assign w_idx    = {r_cnt, 2'b00};

    assign alu_op        = r_op;
    assign alu_a         = r_a[w_idx +: 4];
    assign alu_b         = r_b[w_idx +: 4];
    assign alu_cy_in     = w_first ? (r_op[1] | r_op[3]) : r_cy;
    assign alu_cmp_in    = w_first ? 1'b1 : r_cmpc;
    assign shift_counter = r_cnt;
    assign shift_a       = r_a;
    assign shift_b       = r_b[4:0];
    assign result        = r_result;
    assign cmp           = r_cmp;

    // Shift ops (op[1:0]=01) take their nibble from the shifter, everything else from the ALU.
    assign w_nib = (r_op[1:0] == 2'b01) ? shift_d : alu_d;

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_RUN;
            S_RUN:   if (r_cnt == 3'd7) w_next = S_DONE;
            S_DONE:  w_next = w_accept ? S_RUN : S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // NOTE: every register here uses <= so all updates see pre-edge values of their peers.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt    <= 3'd0;
            r_op     <= 4'd0;
            r_a      <= 32'd0;
            r_b      <= 32'd0;
            r_sr     <= 32'd0;
            r_result <= 32'd0;
            r_cmp    <= 1'b0;
            r_cy     <= 1'b0;
            r_cmpc   <= 1'b0;
        end else if (w_accept) begin
            r_op  <= op;
            r_a   <= a;
            r_b   <= b;
            r_cnt <= 3'd0;
        end else if (r_state == S_RUN) begin
            r_cnt  <= r_cnt + 3'd1;
            r_cy   <= alu_cy_out;
            r_cmpc <= alu_cmp_res;
            r_sr   <= {w_nib, r_sr[31:4]};
            if (r_cnt == 3'd7) begin
                r_cmp    <= alu_cmp_res;
                r_result <= w_slt_op ? {31'd0, alu_cmp_res} : {w_nib, r_sr[31:4]};
            end
        end
    end

endmodule

// File: tb/tb_tiny45_alu_seq.sv
// Directed bench for tiny45_alu_seq with a behavioural 4-bit ALU/shifter hooked to
// the downstream ports; expected results are hand-computed constants.
module tb_tiny45_alu_seq;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic        ready;
    logic        done;
    logic [31:0] result;
    logic        cmp;
    logic [3:0]  alu_op;
    logic [3:0]  alu_a;
    logic [3:0]  alu_b;
    logic        alu_cy_in;
    logic        alu_cmp_in;
    logic [3:0]  alu_d;
    logic        alu_cy_out;
    logic        alu_cmp_res;
    logic [2:0]  shift_counter;
    logic [31:0] shift_a;
    logic [4:0]  shift_b;
    logic [3:0]  shift_d;

    int n_vec = 0;
    int n_err = 0;

    tiny45_alu_seq dut (
        .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
        .ready(ready), .done(done), .result(result), .cmp(cmp),
        .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
        .alu_cy_in(alu_cy_in), .alu_cmp_in(alu_cmp_in),
        .alu_d(alu_d), .alu_cy_out(alu_cy_out), .alu_cmp_res(alu_cmp_res),
        .shift_counter(shift_counter), .shift_a(shift_a), .shift_b(shift_b),
        .shift_d(shift_d)
    );

    always #5 clk = ~clk;

    // Downstream 4-bit ALU: subtract-type ops add ~b; SLT/SLTU derive less-than from the carry.
    logic [3:0]  m_bb;
    logic [4:0]  m_sum;
    logic [31:0] m_shifted;
    always_comb begin
        m_bb        = (alu_op == 4'b0000) ? alu_b : ~alu_b;
        m_sum       = {1'b0, alu_a} + {1'b0, m_bb} + {4'd0, alu_cy_in};
        alu_d       = alu_a;
        alu_cy_out  = 1'b0;
        alu_cmp_res = 1'b0;
        case (alu_op)
            4'b0000, 4'b1000: begin
                alu_d      = m_sum[3:0];
                alu_cy_out = m_sum[4];
            end
            4'b0010: begin
                alu_d       = m_sum[3:0];
                alu_cy_out  = m_sum[4];
                alu_cmp_res = (alu_a[3] ^ alu_b[3]) ? alu_a[3] : ~m_sum[4];
            end
            4'b0011: begin
                alu_d       = m_sum[3:0];
                alu_cy_out  = m_sum[4];
                alu_cmp_res = ~m_sum[4];
            end
            4'b0111: alu_d = alu_a & alu_b;
            4'b0110: alu_d = alu_a | alu_b;
            4'b0100: begin
                alu_d       = alu_a ^ alu_b;
                alu_cmp_res = alu_cmp_in & (alu_a == alu_b);
            end
            default: alu_d = alu_a;
        endcase
        case (alu_op)
            4'b0001: m_shifted = shift_a << shift_b;
            4'b0101: m_shifted = shift_a >> shift_b;
            4'b1101: m_shifted = $signed(shift_a) >>> shift_b;
            default: m_shifted = 32'd0;
        endcase
        shift_d = m_shifted[{shift_counter, 2'b00} +: 4];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issues one op from a ready state, walks the 8 RUN cycles, checks the DONE cycle.
    // glitch >= 0 pulses start (with different operands) during that RUN cycle.
    task automatic run_op(input string name, input logic [3:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] er, input logic ec,
                          input bit chk_cmp, input int glitch);
        op = o; a = x; b = y; start = 1'b1;
        tick();
        start = 1'b0;
        op = 4'b0110; a = ~x; b = ~y;
        for (int k = 0; k < 8; k++) begin
            check({name, "_cnt"}, 32'(shift_counter), 32'(k));
            check({name, "_done_run"}, 32'(done), 32'd0);
            check({name, "_ready_run"}, 32'(ready), 32'd0);
            if (k == 0) check({name, "_cyin0"}, 32'(alu_cy_in), 32'(o[1] | o[3]));
            if (k == glitch) begin
                start = 1'b1;
                tick();
                start = 1'b0;
            end else begin
                tick();
            end
        end
        check({name, "_done"}, 32'(done), 32'd1);
        check({name, "_ready_done"}, 32'(ready), 32'd1);
        check({name, "_result"}, result, er);
        if (chk_cmp) check({name, "_cmp"}, 32'(cmp), 32'(ec));
        tick();
        check({name, "_done_after"}, 32'(done), 32'd0);
        check({name, "_held"}, result, er);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; op = 4'd0; a = 32'd0; b = 32'd0;
        tick();
        start = 1'b1;
        tick();
        check("rst_ready", 32'(ready), 32'd1);
        check("rst_done", 32'(done), 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_cmp", 32'(cmp), 32'd0);
        check("rst_cnt", 32'(shift_counter), 32'd0);
        start = 1'b0;
        rst = 1'b0;
        tick();
        check("idle_done", 32'(done), 32'd0);

        run_op("add_carry", 4'b0000, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b0, -1);
        run_op("sub",       4'b1000, 32'd5,        32'd7,        32'hFFFFFFFE, 1'b0, 1'b0, -1);
        run_op("slt",       4'b0010, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1'b1, 1'b1, -1);
        run_op("sltu",      4'b0011, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1'b0, 1'b1, -1);
        run_op("eq_same",   4'b0100, 32'h12345678, 32'h12345678, 32'h00000000, 1'b1, 1'b1, -1);
        run_op("eq_diff",   4'b0100, 32'h12345678, 32'h12345679, 32'h00000001, 1'b0, 1'b1, -1);
        run_op("and",       4'b0111, 32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000, 1'b0, 1'b0, -1);
        run_op("or",        4'b0110, 32'hF0F0F0F0, 32'hFF00FF00, 32'hFFF0FFF0, 1'b0, 1'b0, -1);
        run_op("sra",       4'b1101, 32'h80000000, 32'd4,        32'hF8000000, 1'b0, 1'b0, -1);
        run_op("srl",       4'b0101, 32'h80000000, 32'd4,        32'h08000000, 1'b0, 1'b0, -1);
        run_op("sll",       4'b0001, 32'h00000001, 32'd4,        32'h00000010, 1'b0, 1'b0, -1);
        run_op("glitch",    4'b0000, 32'h00000010, 32'h00000020, 32'h00000030, 1'b0, 1'b0, 2);
        for (int k = 0; k < 10; k++) begin
            check("glitch_no_done", 32'(done), 32'd0);
            tick();
        end
        check("glitch_result", result, 32'h00000030);

        // Reset mid-RUN at counter 3 abandons the op.
        op = 4'b0000; a = 32'd100; b = 32'd200; start = 1'b1;
        tick();
        start = 1'b0;
        tick(); tick(); tick();
        check("pre_rst_cnt", 32'(shift_counter), 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("midrst_ready", 32'(ready), 32'd1);
        check("midrst_done", 32'(done), 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_cnt", 32'(shift_counter), 32'd0);
        for (int k = 0; k < 10; k++) begin
            check("midrst_no_done", 32'(done), 32'd0);
            tick();
        end
        run_op("add_2_3", 4'b0000, 32'd2, 32'd3, 32'd5, 1'b0, 1'b0, -1);

        // start held high: accepts at the start edge and then out of each DONE cycle.
        op = 4'b0000; a = 32'd1; b = 32'd1; start = 1'b1;
        tick();
        for (int k = 1; k <= 30; k++) begin
            if (k == 19) start = 1'b0;
            check($sformatf("b2b_done_%0d", k), 32'(done),
                  32'((k == 9) || (k == 18) || (k == 27)));
            if ((k == 9) || (k == 18) || (k == 27)) check("b2b_result", result, 32'd2);
            tick();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/tiny45_alu_seq.md
# tiny45_alu_seq

Nibble-serial execution sequencer for the tiny45 datapath. It accepts a 32-bit ALU or shift operation through a start/done handshake and presents the operands to the 4-bit ALU one nibble per cycle, LSB first. It chains carry and compare state between cycles and assembles the 32-bit result from the ALU or shifter output. It sits between instruction decode/register read (upstream) and the 4-bit ALU/shifter (downstream), and returns the completed result to writeback.

## Interface
Parameters: none.

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  request; accepted only when ready=1
- op  in  4  operation code, ALU/shifter encoding: 0000 ADD, 1000 SUB, 0010 SLT, 0011 SLTU, 0111 AND, 0110 OR, 0100 XOR/EQ, 0001 SLL, 0101 SRL, 1101 SRA
- a  in  32  operand A, sampled with start
- b  in  32  operand B, sampled with start
- ready  out  1  high in IDLE and DONE
- done  out  1  one-cycle pulse; result and cmp valid
- result  out  32  final result, held until next accepted start
- cmp  out  1  final compare flag (SLT/SLTU: less-than; 0100: A==B)
- alu_op  out  4  latched op
- alu_a, alu_b  out  4 each  current nibble of latched A/B
- alu_cy_in, alu_cmp_in  out  1 each  chained carry / compare
- alu_d  in  4  ALU nibble result
- alu_cy_out, alu_cmp_res  in  1 each  ALU carry / compare out
- shift_counter  out  3  nibble index
- shift_a  out  32  latched A
- shift_b  out  5  latched B[4:0]
- shift_d  in  4  shifter nibble for shift_counter

## Operation
- States: IDLE → RUN (8 cycles, counter 0..7) → DONE (1 cycle) → IDLE.
- Accept: start=1 while ready=1 latches op, a, b, clears counter and enters RUN. This applies in IDLE and in DONE, which allows back-to-back operations.
- start while in RUN is ignored. Latched operands are unaffected by later input changes.
- Nibble select in RUN: alu_a=A[4c+3:4c] and alu_b=B[4c+3:4c], where c=counter. shift_counter=c.
- Carry chain:
  - At c=0, alu_cy_in = op[1]|op[3].
  - At c>0, alu_cy_in = the registered alu_cy_out from the previous cycle.
- Compare chain:
  - At c=0, alu_cmp_in = 1.
  - At c>0, alu_cmp_in = the registered alu_cmp_res from the previous cycle.
- Nibble source: shift_d when op[1:0]=01 (SLL/SRL/SRA), otherwise alu_d.
- Result assembly: each RUN cycle does result_sr <= {nibble, result_sr[31:4]}. After c=7, result_sr holds the full word.
- Final values, loaded on the RUN→DONE edge:
  - cmp = alu_cmp_res at c=7.
  - For SLT/SLTU (op[3:1]=001), result = {31'b0, alu_cmp_res at c=7}.
  - For all other ops, result = assembled word.
- Unlisted op codes pass alu_d through unchanged; no error is flagged.
- Outputs alu_* and shift_* are don't-care outside RUN but must be driven (not X).

## Timing
- Start accepted at edge T. RUN occupies cycles T+1..T+8 with counter 0..7. done=1 in cycle T+9, and result/cmp are valid from T+9.
- Throughput: one operation per 9 cycles with back-to-back starts (start asserted during DONE).
- ALU and shifter are combinational within each cycle. Carry and compare feedback are registered once per cycle.
- done is high for exactly one cycle per accepted start and never in IDLE.
- Reset (rst=1 at any edge, including mid-RUN):
  - Next state IDLE; the in-flight op is abandoned with no done.
  - Register values: counter=0, result=0, cmp=0, done=0, ready=1, carry/compare regs=0.
- start and rst asserted together: reset wins.

## Test plan
- ADD a=0xFFFFFFFF, b=0x00000001, start at T → done only in T+9, result=0x00000000; carry propagates through all 8 nibbles.
- SUB a=5, b=7 → result=0xFFFFFFFE. SLT a=0xFFFFFFFF, b=1 → result=1, cmp=1. SLTU with the same operands → result=0, cmp=0.
- XOR/EQ: a=b=0x12345678 → result=0, cmp=1. a=0x12345678, b=0x12345679 → result=0x00000001, cmp=0.
- Shifts with b=4:
  - SRA a=0x80000000 → 0xF8000000.
  - SRL a=0x80000000 → 0x08000000.
  - SLL a=0x00000001 → 0x00000010.
- Handshake: start held high continuously → ops accepted at T, T+9, T+18; one done each. start pulse during RUN → ignored; result unchanged.
- Reset at counter=3 → IDLE next cycle, no done, result=0, ready=1. A following ADD 2+3 → 5.
